mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 25 ++
 rtl/mem_responder_sp_ram.sv | 43 ++++
 rtl/mem_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder: default bus/memory widths, the
// default halt opcode, the responder FSM state encoding and a small opcode
// decode helper.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int         DATA_W_DEF  = 16;
    localparam int         ADDR_W_DEF  = 7;
    localparam logic [3:0] HALT_OP_DEF = 4'b1111;

    // Responder FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    // Opcode lives in the top nibble of a 16-bit instruction word.
    function automatic logic is_halt(input logic [15:0] word, input logic [3:0] op);
        return word[15:12] == op;
    endfunction

endpackage

// File: rtl/mem_responder_sp_ram.sv
// -----------------------------------------------------------------------------
// sp_ram
// 2**ADDR_W x DATA_W RAM with one write port and one synchronous read port
// (one cycle read latency). When a write and a read hit the same address in
// the same cycle the read returns the newly written data (write-first).
// Contents are never cleared.
//
// Ports:
//   clk    in   clock, all updates on rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  registered read data, valid the cycle after raddr is applied
// -----------------------------------------------------------------------------
module sp_ram
    import mem_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Instruction/data memory front end for a simple processor. After Start it
// fetches words from PROG_START onward, presents each on DIN with Run high,
// and waits in EXEC for Done. While executing, the processor can load (AddrIn)
// and store (DoutIn + WrEn) through the same RAM. A HALT_OP word stops
// fetching until the next Start.
//
// Ports:
//   Clock     in   clock
//   Reset     in   synchronous active-high reset
//   Start     in   start pulse (honoured in IDLE and HALT only)
//   BusWires  in   processor bus, sampled on AddrIn / DoutIn in EXEC
//   AddrIn    in   latch bus address into the address register
//   DoutIn    in   latch bus data into the write-data register
//   WrEn      in   store request, qualified with DoutIn
//   Done      in   instruction complete (honoured in EXEC only)
//   DIN       out  fetched instruction or load data
//   Run       out  processor run enable
//   Busy      out  high in FETCH, ISSUE and EXEC
//   Halted    out  high in HALT
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] PROG_START = '0,
    parameter logic [3:0]        HALT_OP    = HALT_OP_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] BusWires,
    input  logic              AddrIn,
    input  logic              DoutIn,
    input  logic              WrEn,
    input  logic              Done,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Halted
);

    logic [2:0]        state_q;
    logic [ADDR_W-1:0] fpc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] din_hold_q;
    logic              ld_vld_p1;
    logic              ld_vld_p2;
    logic              wr_vld_p1;

    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_q;
    logic              ram_we;
    logic              in_exec;
    logic              issue_halt;
    logic              show_ram;

    assign in_exec    = (state_q == ST_EXEC);
    assign issue_halt = is_halt(ram_q[15:0], HALT_OP);

    // The read port follows fpc only while fetching; otherwise it tracks the
    // load/store address so load data refreshes every cycle.
    assign ram_raddr = (state_q == ST_FETCH) ? fpc_q : addr_q;

    // Reset in the write cycle discards the pending store.
    assign ram_we = wr_vld_p1 && !Reset;

    sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (Clock),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // DIN is driven straight from the RAM register during ISSUE and once load
    // data is valid; otherwise it replays the last value it showed. din_hold_q
    // therefore also serves as the captured instruction word.
    assign show_ram = (state_q == ST_ISSUE) || ld_vld_p2;
    assign DIN      = show_ram ? ram_q : din_hold_q;

    // Decoded from registered state and the registered RAM output only, so
    // Done never reaches Run combinationally.
    assign Run    = ((state_q == ST_ISSUE) && !issue_halt) || in_exec;
    assign Busy   = (state_q == ST_FETCH) || (state_q == ST_ISSUE) || in_exec;
    assign Halted = (state_q == ST_HALT);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            fpc_q      <= PROG_START;
            addr_q     <= '0;
            wdata_q    <= '0;
            din_hold_q <= '0;
            ld_vld_p1  <= 1'b0;
            ld_vld_p2  <= 1'b0;
            wr_vld_p1  <= 1'b0;
        end else begin
            din_hold_q <= DIN;

            // Stage p1: address latched, RAM read of the new address in flight.
            ld_vld_p1 <= in_exec && AddrIn;
            // Stage p2: load data on ram_q; held until a new AddrIn or EXEC exit.
            ld_vld_p2 <= in_exec && !Done && !AddrIn && (ld_vld_p1 || ld_vld_p2);
            // Stage p1: store data latched, write issued in the following cycle.
            wr_vld_p1 <= in_exec && DoutIn && !AddrIn && WrEn;

            if (in_exec && AddrIn) begin
                addr_q <= BusWires[ADDR_W-1:0];
            end else if (in_exec && DoutIn) begin
                wdata_q <= BusWires;
            end

            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (Start) begin
                        state_q <= ST_FETCH;
                        fpc_q   <= PROG_START;
                    end
                end
                ST_FETCH: state_q <= ST_ISSUE;
                ST_ISSUE: begin
                    if (issue_halt) begin
                        state_q <= ST_HALT;
                    end else begin
                        state_q <= ST_EXEC;
                        fpc_q   <= fpc_q + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (Done) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
